// File: rtl/biquad_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package biquad_pkg;

    // Coefficient slots within one section; a0 is implicit (1.0 in Q.FRAC).
    localparam int B0            = 0;
    localparam int B1            = 1;
    localparam int B2            = 2;
    localparam int A1            = 3;
    localparam int A2            = 4;
    localparam int COEFS_PER_SEC = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Clamp a wide signed value to the signed range of an io_w-bit word.
    // The caller keeps the low io_w bits of the result.
    function automatic logic signed [63:0] sat_io(input logic signed [63:0] v,
                                                  input int io_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (io_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (io_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    // Reset value of a coefficient slot: passthrough (b0 = 1.0, all others 0).
    function automatic logic signed [31:0] passthru_coef(input int slot, input int frac);
        return (slot == B0) ? (32'sd1 <<< frac) : 32'sd0;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Registered multiply-accumulate: acc <= (load ? init : acc) +/- coef*data, with sat(acc>>>FRAC) out.
// Latency: 1 cycle from operands to acc; sat_out is combinational from the registered acc.
// Backpressure: none; en gates the update.
// Ports: clk/reset; en, load, neg select the operation; init is the load base;
//        coef/data are the multiplier operands; sat_out = sat_IO(acc >>> FRAC).
module biquad_mac
    import biquad_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int IO_W   = 16,
    parameter int ACC_W  = 36,
    parameter int FRAC   = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     load,
    input  logic                     neg,
    input  logic signed [ACC_W-1:0]  init,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [IO_W-1:0]   data,
    output logic signed [IO_W-1:0]   sat_out
);

    localparam int P_W = COEF_W + IO_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      sat_wide;

    always_comb begin
        prod     = coef * data;
        prod_ext = ACC_W'(prod);
        base     = load ? init : acc;
        acc_next = neg ? (base - prod_ext) : (base + prod_ext);
        // Arithmetic shift floors toward minus infinity; no rounding.
        shifted  = acc >>> FRAC;
        sat_wide = sat_io(64'(shifted), IO_W);
        sat_out  = sat_wide[IO_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/biquad_cascade_tdm.sv
// Multi-channel cascade of N_SEC DF-II biquads sharing one MAC, with per-channel/per-section state.
// Latency: m_valid rises 5*N_SEC+1 cycles after the accept edge; one sample in flight at a time.
// Backpressure: s_ready low outside IDLE; OUT holds m_valid/m_data/m_ch stable until m_ready.
// Ports: s_valid/s_ready/s_ch/s_data input stream; m_valid/m_ready/m_ch/m_data output stream;
//        cfg_we/cfg_addr/cfg_data coefficient writes (addr = sec*5 + {b0,b1,b2,a1,a2});
//        clr_state zeroes delay state and aborts; busy is high outside IDLE.
module biquad_cascade_tdm
    import biquad_pkg::*;
#(
    parameter  int IO_W   = 16,
    parameter  int COEF_W = 16,
    parameter  int FRAC   = 14,
    parameter  int N_SEC  = 4,
    parameter  int N_CH   = 2,
    parameter  int ACC_W  = IO_W + COEF_W + 4,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CA_W   = $clog2(N_SEC * COEFS_PER_SEC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [CH_W-1:0]          s_ch,
    input  logic signed [IO_W-1:0]   s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CH_W-1:0]          m_ch,
    output logic signed [IO_W-1:0]   m_data,
    input  logic                     cfg_we,
    input  logic [CA_W-1:0]          cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_data,
    input  logic                     clr_state,
    output logic                     busy
);

    localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int N_ST   = N_CH * N_SEC;
    localparam int SI_W   = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam int N_COEF = N_SEC * COEFS_PER_SEC;
    // Extra RUN step after the last section: the final acc is only visible
    // from the MAC register one cycle after step 4, so it is captured here.
    localparam logic [2:0] STEP_WB = 3'd5;

    state_t                  state_q, state_d;
    logic [SEC_W-1:0]        sec_q;
    logic [2:0]              step_q;
    logic [CH_W-1:0]         ch_q;
    logic signed [IO_W-1:0]  x_in_q;
    logic signed [IO_W-1:0]  w_q;

    logic signed [COEF_W-1:0] coef_q [N_COEF];
    logic signed [IO_W-1:0]   w1_q   [N_ST];
    logic signed [IO_W-1:0]   w2_q   [N_ST];

    logic                    accept;
    logic                    ch_ok;
    logic                    last_sec;
    int                      coef_k;
    logic [CA_W-1:0]         coef_idx;
    logic [SI_W-1:0]         st_idx;
    logic signed [COEF_W-1:0] coef_rd;
    logic signed [IO_W-1:0]  w1_rd;
    logic signed [IO_W-1:0]  w2_rd;
    logic signed [IO_W-1:0]  sec_in;
    logic                    mac_en;
    logic                    mac_load;
    logic                    mac_neg;
    logic signed [ACC_W-1:0] mac_init;
    logic signed [IO_W-1:0]  mac_data;
    logic signed [IO_W-1:0]  mac_sat;

    // FSM next state and stream handshake outputs.
    always_comb begin
        s_ready  = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        m_valid  = (state_q == ST_OUT);
        accept   = s_valid && s_ready && !clr_state;
        ch_ok    = (int'(s_ch) < N_CH);
        last_sec = (int'(sec_q) == N_SEC - 1);
        state_d  = state_q;
        case (state_q)
            ST_IDLE: if (accept && ch_ok)        state_d = ST_RUN;
            ST_RUN:  if (step_q == STEP_WB)      state_d = ST_OUT;
            ST_OUT:  if (m_ready)                state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
        if (clr_state)
            state_d = ST_IDLE;
    end

    // Operand selection for the shared MAC, one product per step.
    always_comb begin
        st_idx   = SI_W'(int'(ch_q) * N_SEC + int'(sec_q));
        w1_rd    = w1_q[st_idx];
        w2_rd    = w2_q[st_idx];
        // Section 0 reads the accepted sample; later sections read the previous
        // section's output straight from the MAC register (left by its step 4).
        sec_in   = (sec_q == '0) ? x_in_q : mac_sat;
        mac_en   = (state_q == ST_RUN) && (step_q != STEP_WB);
        mac_load = 1'b0;
        mac_neg  = 1'b0;
        mac_init = '0;
        mac_data = w1_rd;
        coef_k   = A1;
        case (step_q)
            3'd0: begin
                coef_k   = A1;
                mac_data = w1_rd;
                mac_load = 1'b1;
                mac_neg  = 1'b1;
                mac_init = ACC_W'(sec_in) <<< FRAC;
            end
            3'd1: begin
                coef_k   = A2;
                mac_data = w2_rd;
                mac_neg  = 1'b1;
            end
            3'd2: begin
                coef_k   = B0;
                mac_data = mac_sat;
                mac_load = 1'b1;
            end
            3'd3: begin
                coef_k   = B1;
                mac_data = w1_rd;
            end
            3'd4: begin
                coef_k   = B2;
                mac_data = w2_rd;
            end
            default: ;
        endcase
        coef_idx = CA_W'(int'(sec_q) * COEFS_PER_SEC + coef_k);
        coef_rd  = coef_q[coef_idx];
    end

    biquad_mac #(
        .COEF_W (COEF_W),
        .IO_W   (IO_W),
        .ACC_W  (ACC_W),
        .FRAC   (FRAC)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en      (mac_en),
        .load    (mac_load),
        .neg     (mac_neg),
        .init    (mac_init),
        .coef    (coef_rd),
        .data    (mac_data),
        .sat_out (mac_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            step_q  <= '0;
            ch_q    <= '0;
            x_in_q  <= '0;
            w_q     <= '0;
            m_data  <= '0;
            m_ch    <= '0;
            for (int i = 0; i < N_ST; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (clr_state) begin
                for (int i = 0; i < N_ST; i++) begin
                    w1_q[i] <= '0;
                    w2_q[i] <= '0;
                end
            end else begin
                // Out-of-range channels are accepted but leave everything untouched.
                if (accept && ch_ok) begin
                    x_in_q <= s_data;
                    ch_q   <= s_ch;
                    sec_q  <= '0;
                    step_q <= '0;
                end
                if (state_q == ST_RUN) begin
                    if (step_q == 3'd4 && !last_sec) begin
                        step_q <= '0;
                        sec_q  <= sec_q + SEC_W'(1);
                    end else if (step_q != STEP_WB) begin
                        step_q <= step_q + 3'd1;
                    end
                    // w is visible from the MAC once step 1 has landed; keep it
                    // for the delay-line update at step 4.
                    if (step_q == 3'd2)
                        w_q <= mac_sat;
                    if (step_q == 3'd4) begin
                        w2_q[st_idx] <= w1_rd;
                        w1_q[st_idx] <= w_q;
                    end
                    if (step_q == STEP_WB) begin
                        m_data <= mac_sat;
                        m_ch   <= ch_q;
                    end
                end
            end
        end
    end

    // Coefficient file: writes land on the next edge in any state and survive clr_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_COEF; i++)
                coef_q[i] <= COEF_W'(passthru_coef(i % COEFS_PER_SEC, FRAC));
        end else if (cfg_we && (int'(cfg_addr) < N_COEF)) begin
            coef_q[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// Directed self-checking bench for biquad_cascade_tdm at default parameters.
// Latency: n/a.
// Backpressure: exercised by holding m_ready low in one scenario.
module tb_biquad_cascade_tdm;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic [0:0]         s_ch;
    logic signed [15:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic [0:0]         m_ch;
    logic signed [15:0] m_data;
    logic               cfg_we;
    logic [4:0]         cfg_addr;
    logic signed [15:0] cfg_data;
    logic               clr_state;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biquad_cascade_tdm dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_ch      (s_ch),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_ch      (m_ch),
        .m_data    (m_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .clr_state (clr_state),
        .busy      (busy)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_data = 16'(val);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_state = 1'b1;
        step();
        clr_state = 1'b0;
    endtask

    task automatic set_sec0(input int b0, input int b1, input int b2, input int a1, input int a2);
        cfg_write(0, b0);
        cfg_write(1, b1);
        cfg_write(2, b2);
        cfg_write(3, a1);
        cfg_write(4, a2);
    endtask

    // Push one sample, wait (bounded) for the result, accept it. lat counts edges
    // from the accept edge to m_valid; 200 means it never came.
    task automatic run_sample(input logic [0:0] ch, input logic signed [15:0] x,
                              output logic signed [15:0] y, output logic [0:0] ych,
                              output int lat);
        s_valid = 1'b1;
        s_ch    = ch;
        s_data  = x;
        step();
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 200) begin
            step();
            lat++;
        end
        y   = m_data;
        ych = m_ch;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (m_data !== 16'sd0) begin errors++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        checks++; if (m_ch !== 1'b0) begin errors++; $display("FAIL reset_m_ch got %0d want 0", m_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    endtask

    task automatic test_passthrough();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        run_sample(1'b0, 16'sd1000, y, yc, lat);
        checks++; if (y !== 16'sd1000) begin errors++; $display("FAIL pass_data got %0d want 1000", y); end
        checks++; if (yc !== 1'b0) begin errors++; $display("FAIL pass_ch got %0d want 0", yc); end
        checks++; if (lat != 21) begin errors++; $display("FAIL pass_latency got %0d want 21", lat); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pass_valid_drop got %0b want 0", m_valid); end
        run_sample(1'b0, -16'sd32768, y, yc, lat);
        checks++; if (y !== -16'sd32768) begin errors++; $display("FAIL pass_min got %0d want -32768", y); end
        run_sample(1'b1, 16'sd1000, y, yc, lat);
        checks++; if (yc !== 1'b1) begin errors++; $display("FAIL pass_ch1 got %0d want 1", yc); end
    endtask

    task automatic test_fir();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        int exp_y [5] = '{4096, 4096, 4096, 0, 0};
        logic signed [15:0] x;
        set_sec0(4096, 4096, 4096, 0, 0);
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            x = (i == 0) ? 16'sd16384 : 16'sd0;
            run_sample(1'b0, x, y, yc, lat);
            checks++;
            if (y !== 16'(exp_y[i])) begin
                errors++;
                $display("FAIL fir_out[%0d] got %0d want %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_feedback();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        int exp_y [5] = '{16384, 8192, 4096, 2048, 1024};
        logic signed [15:0] x;
        set_sec0(16384, 0, 0, -8192, 0);
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            x = (i == 0) ? 16'sd16384 : 16'sd0;
            run_sample(1'b0, x, y, yc, lat);
            checks++;
            if (y !== 16'(exp_y[i])) begin
                errors++;
                $display("FAIL iir_out[%0d] got %0d want %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_channels();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        int exp_y [5] = '{16384, 8192, 4096, 2048, 1024};
        logic signed [15:0] x;
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            x = (i == 0) ? 16'sd16384 : 16'sd0;
            run_sample(1'b0, x, y, yc, lat);
            checks++;
            if (y !== 16'(exp_y[i]) || yc !== 1'b0) begin
                errors++;
                $display("FAIL chan0_out[%0d] got %0d/ch%0d want %0d/ch0", i, y, yc, exp_y[i]);
            end
            run_sample(1'b1, 16'sd0, y, yc, lat);
            checks++;
            if (y !== 16'sd0 || yc !== 1'b1) begin
                errors++;
                $display("FAIL chan1_out[%0d] got %0d/ch%0d want 0/ch1", i, y, yc);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        set_sec0(32767, 0, 0, 0, 0);
        pulse_clr();
        run_sample(1'b0, 16'sd30000, y, yc, lat);
        checks++; if (y !== 16'sd32767) begin errors++; $display("FAIL sat_pos got %0d want 32767", y); end
        pulse_clr();
        run_sample(1'b0, -16'sd30000, y, yc, lat);
        checks++; if (y !== -16'sd32768) begin errors++; $display("FAIL sat_neg got %0d want -32768", y); end
    endtask

    task automatic test_backpressure();
        int n;
        set_sec0(16384, 0, 0, 0, 0);
        pulse_clr();
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 16'sd500;
        step();
        s_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_run got %0b want 1", busy); end
        n = 0;
        while (!m_valid && n < 200) begin
            step();
            n++;
        end
        checks++; if (n != 21) begin errors++; $display("FAIL bp_latency got %0d want 21", n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'sd500 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b d=%0d rdy=%0b want v=1 d=500 rdy=0",
                         i, m_valid, m_data, s_ready);
            end
            step();
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_single got %0b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %0b want 1", s_ready); end
    endtask

    task automatic test_clr_abort();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        int seen;
        set_sec0(16384, 0, 0, -8192, 0);
        pulse_clr();
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 16'sd16384;
        step();
        s_valid = 1'b0;
        repeat (8) step();
        pulse_clr();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %0b want 0", busy); end
        seen = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) seen++;
            step();
        end
        m_ready = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL clr_no_output got %0d valid cycles want 0", seen); end
        run_sample(1'b0, 16'sd16384, y, yc, lat);
        checks++; if (y !== 16'sd16384) begin errors++; $display("FAIL clr_fresh0 got %0d want 16384", y); end
        run_sample(1'b0, 16'sd0, y, yc, lat);
        checks++; if (y !== 16'sd8192) begin errors++; $display("FAIL clr_fresh1 got %0d want 8192", y); end
    endtask

    task automatic test_reset_midrun();
        logic signed [15:0] y;
        logic [0:0] yc;
        int lat;
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 16'sd16384;
        step();
        s_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_run_s_ready got %0b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_run_m_valid got %0b want 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %0b want 0", busy); end
        checks++; if (m_data !== 16'sd0) begin errors++; $display("FAIL rst_run_m_data got %0d want 0", m_data); end
        step();
        reset = 1'b0;
        step();
        // Feedback coefficient and delay state must both be gone.
        run_sample(1'b0, 16'sd1000, y, yc, lat);
        checks++; if (y !== 16'sd1000) begin errors++; $display("FAIL rst_pass0 got %0d want 1000", y); end
        run_sample(1'b0, 16'sd0, y, yc, lat);
        checks++; if (y !== 16'sd0) begin errors++; $display("FAIL rst_pass1 got %0d want 0", y); end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_ch      = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        clr_state = 1'b0;
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_passthrough();
        test_fir();
        test_feedback();
        test_channels();
        test_saturation();
        test_backpressure();
        test_clr_abort();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
